// File: rtl/pat_scan_ctrl.sv
// 4-bit pattern counter over a 64-bit string, one byte per cycle MSB-first (in-byte, byte-hit and full-string counts).
// Latency: done pulses 8 edges after the edge that accepts start; start is ignored while busy or done.
module pat_scan_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  pat,
  input  logic [63:0] str,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ctb,
  output logic [7:0]  cto,
  output logic [7:0]  cts
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  pat_q, pat_d;
  logic [63:0] str_q, str_d;
  logic [2:0]  prev_q, prev_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  cto_q, cto_d;
  logic [7:0]  cts_q, cts_d;

  logic [7:0]  cur_byte;
  logic [10:0] win;
  logic [2:0]  n_byte;
  logic [1:0]  n_strad;

  // Only the low 3 bits of the higher byte can fall inside a straddle window (offsets 5..7).
  always_comb begin
    cur_byte = str_q[63:56];
    win      = {prev_q, cur_byte};
    n_byte   = 3'd0;
    n_strad  = 2'd0;
    for (int p = 0; p < 5; p++) begin
      if (cur_byte[p +: 4] == pat_q) n_byte = n_byte + 3'd1;
    end
    for (int p = 5; p < 8; p++) begin
      if ((win[p +: 4] == pat_q) && (idx_q != 3'd0)) n_strad = n_strad + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    str_d   = str_q;
    prev_d  = prev_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          pat_d   = pat;
          str_d   = str;
          idx_d   = 3'd0;
          prev_d  = 3'd0;
          ctb_d   = 8'd0;
          cto_d   = 8'd0;
          cts_d   = 8'd0;
        end
      end
      SCAN: begin
        ctb_d  = ctb_q + {5'd0, n_byte};
        cto_d  = cto_q + {7'd0, (n_byte != 3'd0)};
        cts_d  = cts_q + {5'd0, n_byte} + {6'd0, n_strad};
        prev_d = cur_byte[2:0];
        str_d  = {str_q[55:0], 8'h00};
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      pat_q   <= 4'd0;
      str_q   <= 64'd0;
      prev_q  <= 3'd0;
      ctb_q   <= 8'd0;
      cto_q   <= 8'd0;
      cts_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      str_q   <= str_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
  assign ctb  = ctb_q;
  assign cto  = cto_q;
  assign cts  = cts_q;

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// Bench for pat_scan_ctrl: window-counting reference model, per-cycle compare, directed corner cases and random scans.
module tb_pat_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  pat;
  logic [63:0] str;
  logic        busy;
  logic        done;
  logic [7:0]  ctb;
  logic [7:0]  cto;
  logic [7:0]  cts;

  int n_chk;
  int n_fail;

  // Model: phase -1 = idle, 0..7 = scanning, 8 = done cycle.
  int phase;
  int exp_ctb, exp_cto, exp_cts;
  int pend_b, pend_o, pend_t;

  pat_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .pat   (pat),
    .str   (str),
    .busy  (busy),
    .done  (done),
    .ctb   (ctb),
    .cto   (cto),
    .cts   (cts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counts straight from the window definitions over the whole string.
  function automatic void ref_counts(input logic [3:0] p, input logic [63:0] s,
                                     output int b, output int o, output int t);
    b = 0; o = 0; t = 0;
    for (int by = 0; by < 8; by++) begin
      int c;
      c = 0;
      for (int k = 0; k < 5; k++) if (s[by*8+k +: 4] == p) c++;
      b += c;
      if (c > 0) o++;
    end
    for (int off = 0; off <= 60; off++) if (s[off +: 4] == p) t++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = -1;
      exp_ctb = 0; exp_cto = 0; exp_cts = 0;
    end else if (phase < 0) begin
      if (start) begin
        phase = 0;
        ref_counts(pat, str, pend_b, pend_o, pend_t);
        exp_ctb = 0; exp_cto = 0; exp_cts = 0;
      end
    end else if (phase == 8) begin
      phase = -1;
    end else begin
      phase++;
      if (phase == 8) begin
        exp_ctb = pend_b; exp_cto = pend_o; exp_cts = pend_t;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(phase >= 0 && phase < 8));
    chk("done", int'(done), int'(phase == 8));
    if (!(phase >= 0 && phase < 8)) begin
      chk("ctb", int'(ctb), exp_ctb);
      chk("cto", int'(cto), exp_cto);
      chk("cts", int'(cts), exp_cts);
    end
  end

  task automatic run_scan(input logic [3:0] p, input logic [63:0] s, input bit noise,
                          input int eb, input int eo, input int et, input string tag);
    int bc;
    int k;
    @(negedge clk);
    pat = p; str = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    k = 0;
    while (!done && k < 20) begin
      if (busy) bc++;
      if (noise) begin
        start = 1'b1;
        pat   = 4'h0;
        str   = {$urandom, $urandom};
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(done), 1);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_ctb"}, int'(ctb), eb);
    chk({tag, "_cto"}, int'(cto), eo);
    chk({tag, "_cts"}, int'(cts), et);
  endtask

  initial begin
    int b, o, t;
    int ndone;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; pat = 4'h0; str = 64'h0;
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cts", int'(cts), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ref_counts(4'h0, 64'h0, b, o, t);
    chk("model_zero", b * 10000 + o * 100 + t, 40 * 10000 + 8 * 100 + 61);
    ref_counts(4'hA, 64'h0000_0000_0000_0280, b, o, t);
    chk("model_straddle", b * 10000 + o * 100 + t, 1);
    ref_counts(4'hA, 64'h0000_0000_0000_000A, b, o, t);
    chk("model_single", b * 10000 + o * 100 + t, 10101);

    run_scan(4'h0, 64'h0, 1'b0, 40, 8, 61, "zeros");
    run_scan(4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 40, 8, 61, "ones");
    run_scan(4'hA, 64'h0000_0000_0000_000A, 1'b0, 1, 1, 1, "single");
    run_scan(4'hA, 64'h0000_0000_0000_0280, 1'b0, 0, 0, 1, "straddle");
    run_scan(4'hA, 64'h0000_0000_0000_000A, 1'b1, 1, 1, 1, "ignore");

    // Abort during the 4th scan cycle.
    @(negedge clk);
    pat = 4'hF; str = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ctb", int'(ctb), 0);
    chk("abort_cto", int'(cto), 0);
    chk("abort_cts", int'(cts), 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_scan(4'h0, 64'h0, 1'b0, 40, 8, 61, "after_abort");

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      pat   = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       str = {$urandom, $urandom};
        1:       str = {8{8'($urandom)}};
        default: str = {16{pat}} ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
